jk_cmd_sequencer: RTL and testbench
===================================

JK_CMD_SEQUENCER -- requirements
Module: jk_cmd_sequencer

Interface
REQ-001 The block SHALL have parameter CNT_W, default 4, which sets the repeat-count width in bits.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port RST_N, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port CMD, input, 2 bits, with this encoding:
- 00 HOLD
- 01 RESET
- 10 SET
- 11 TOGGLE
REQ-005 The block SHALL have port CNT, input, CNT_W bits: the number of cycles the command is driven.
REQ-006 The block SHALL have port CMD_VALID, input, 1 bit: CMD and CNT are valid.
REQ-007 The block SHALL have port CMD_READY, output, 1 bit: the block accepts a command.
REQ-008 The block SHALL have ports J and K, outputs, 1 bit each: registered drive to the downstream JK flip-flop.
REQ-009 The block SHALL have port Q_FB, input, 1 bit: Q fed back from the downstream JK flip-flop.
REQ-010 The block SHALL have port EXP_Q, output, 1 bit: the modelled expected flip-flop state.
REQ-011 The block SHALL have port BUSY, output, 1 bit: high when not in IDLE.
REQ-012 The block SHALL have port DONE, output, 1 bit: one-cycle completion pulse.
REQ-013 The block SHALL have port ERR, output, 1 bit: sticky flag for Q_FB/EXP_Q mismatch.

Function
REQ-014 The block SHALL implement FSM states IDLE, DRIVE and CHECK.
REQ-015 In IDLE, CMD_READY SHALL be 1; in all other states it SHALL be 0.
REQ-016 A command SHALL be accepted on a rising edge where CMD_VALID=1 and CMD_READY=1; CMD and CNT are captured at that edge.
REQ-017 CMD_VALID while CMD_READY=0 SHALL be ignored and not queued.
REQ-018 On accept with CNT>=1, the FSM SHALL go to DRIVE; with CNT=0, it SHALL go directly to CHECK.
REQ-019 In DRIVE, J and K SHALL equal the captured CMD bits (J=CMD[1], K=CMD[0]) for exactly CNT consecutive cycles, starting the cycle after accept.
REQ-020 After the last DRIVE cycle, the FSM SHALL go to CHECK.
REQ-021 Outside DRIVE, J and K SHALL be 0 (hold).
REQ-022 The DRIVE down-counter SHALL be CNT_W bits wide and load CNT on accept.
REQ-023 The maximum CNT (2^CNT_W-1) SHALL be driven fully, with no wrap to 0.
REQ-024 EXP_Q SHALL be updated once per DRIVE cycle, following the JK table:
- HOLD: keep
- RESET: 0
- SET: 1
- TOGGLE: invert
REQ-025 The block SHALL keep an internal flag KNOWN, cleared by reset and set by any DRIVE cycle with a RESET or SET command.
REQ-026 The CHECK state SHALL last exactly 1 cycle; at the edge closing CHECK, if KNOWN=1 and Q_FB!=EXP_Q, ERR SHALL be set.
REQ-027 If KNOWN=0, no mismatch SHALL be flagged.
REQ-028 ERR SHALL be sticky and clear only on reset.
REQ-029 After CHECK, the FSM SHALL return to IDLE, and DONE SHALL be 1 for exactly the first IDLE cycle; that cycle also has CMD_READY=1.
REQ-030 A command accepted in that same cycle SHALL proceed normally, giving back-to-back operation.
REQ-031 Total latency from accept edge to DONE high SHALL be CNT+2 cycles.
REQ-032 BUSY SHALL equal (state != IDLE).
REQ-033 CMD and CNT changes during DRIVE or CHECK SHALL have no effect.
REQ-034 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-035 RST_N=0 SHALL, asynchronously, force the following values:
- state IDLE, counter 0
- J=0, K=0
- EXP_Q=0, KNOWN=0
- ERR=0, DONE=0, BUSY=0
- CMD_READY=1
REQ-036 Reset asserted mid-DRIVE or mid-CHECK SHALL abort the operation with no DONE pulse.
REQ-037 After reset release, the first rising edge SHALL be able to accept a command.

Verification
REQ-038 The bench SHALL cover SET, CNT=1: J=1, K=0 for 1 cycle; EXP_Q=1; with an ideal JK FF model, Q_FB=1; DONE 3 cycles after accept; ERR=0.
REQ-039 The bench SHALL cover TOGGLE, CNT=3, after SET: J=K=1 for 3 cycles; EXP_Q=0; DONE at accept+5; ERR=0.
REQ-040 The bench SHALL cover RESET, CNT=2, with Q_FB forced to 1: at CHECK, ERR=1, and ERR stays 1 through a following HOLD command.
REQ-041 The bench SHALL cover TOGGLE straight after reset (KNOWN=0) with Q_FB mismatching: ERR=0.
REQ-042 The bench SHALL cover CNT=0 and back-to-back operation:
- HOLD with CNT=0: no J/K activity; DONE at accept+2.
- A second command with CMD_VALID held high is accepted in the DONE cycle.
REQ-043 The bench SHALL cover RST_N pulsed low during DRIVE of TOGGLE with CNT=15: J=K=0 immediately, no DONE, CMD_READY=1, EXP_Q=0.

Source files
------------

// File: rtl/jk_cmd_sequencer.sv
// Command sequencer for a downstream JK flip-flop: drives J/K for a counted
// number of cycles, models the expected Q, then checks the fed-back Q once.
module jk_cmd_sequencer #(
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [1:0]       CMD,
  input  logic [CNT_W-1:0] CNT,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  output logic             J,
  output logic             K,
  input  logic             Q_FB,
  output logic             EXP_Q,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);

  localparam logic [1:0] CMD_HOLD   = 2'b00;
  localparam logic [1:0] CMD_RESET  = 2'b01;
  localparam logic [1:0] CMD_SET    = 2'b10;
  localparam logic [1:0] CMD_TOGGLE = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cmd_q, cmd_d;
  logic             j_q, j_d;
  logic             k_q, k_d;
  logic             expq_q, expq_d;
  logic             known_q, known_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cmd_q   <= CMD_HOLD;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
      expq_q  <= 1'b0;
      known_q <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      j_q     <= j_d;
      k_q     <= k_d;
      expq_q  <= expq_d;
      known_q <= known_d;
      err_q   <= err_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    j_d     = 1'b0;
    k_d     = 1'b0;
    expq_d  = expq_q;
    known_d = known_q;
    err_d   = err_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (CMD_VALID) begin
          cmd_d = CMD;
          cnt_d = CNT;
          if (CNT != '0) begin
            // J/K are registered, so they must be loaded at the accept edge
            // to be visible during the first DRIVE cycle.
            state_d = S_DRIVE;
            j_d     = CMD[1];
            k_d     = CMD[0];
          end else begin
            state_d = S_CHECK;
          end
        end
      end

      S_DRIVE: begin
        case (cmd_q)
          CMD_HOLD:   expq_d = expq_q;
          CMD_RESET:  expq_d = 1'b0;
          CMD_SET:    expq_d = 1'b1;
          CMD_TOGGLE: expq_d = ~expq_q;
          default:    expq_d = expq_q;
        endcase
        if ((cmd_q == CMD_RESET) || (cmd_q == CMD_SET)) begin
          known_d = 1'b1;
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_CHECK;
        end else begin
          j_d = cmd_q[1];
          k_d = cmd_q[0];
        end
      end

      S_CHECK: begin
        // Until a RESET or SET has been driven the real flop state is unknown.
        if (known_q && (Q_FB != expq_q)) begin
          err_d = 1'b1;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  assign CMD_READY = ready_q;
  assign J         = j_q;
  assign K         = k_q;
  assign EXP_Q     = expq_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Scoreboard bench for jk_cmd_sequencer: the driver pushes expected results
// from a reference model at accept time; a negedge monitor compares them.
module tb_jk_cmd_sequencer;

  localparam int CNT_W = 4;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b1;
  logic [1:0]       CMD = 2'b00;
  logic [CNT_W-1:0] CNT = '0;
  logic             CMD_VALID = 1'b0;
  logic             CMD_READY;
  logic             J, K;
  logic             Q_FB;
  logic             EXP_Q, BUSY, DONE, ERR;

  jk_cmd_sequencer #(.CNT_W(CNT_W)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .CMD       (CMD),
    .CNT       (CNT),
    .CMD_VALID (CMD_VALID),
    .CMD_READY (CMD_READY),
    .J         (J),
    .K         (K),
    .Q_FB      (Q_FB),
    .EXP_Q     (EXP_Q),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .ERR       (ERR)
  );

  always #5 CLK = ~CLK;

  // Ideal downstream JK flip-flop, with an optional override of its feedback.
  logic ff_q;
  bit   force_en = 1'b0;
  bit   force_val = 1'b0;
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) ff_q <= 1'b0;
    else begin
      case ({J, K})
        2'b01: ff_q <= 1'b0;
        2'b10: ff_q <= 1'b1;
        2'b11: ff_q <= ~ff_q;
        default: ff_q <= ff_q;
      endcase
    end
  end
  assign Q_FB = force_en ? force_val : ff_q;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  typedef struct {
    int cmd;
    int cnt;
    int acc;
    bit exp_after;
    bit err_before;
    bit err_after;
  } item_t;

  item_t sb_q[$];

  // Reference model state: flop value, whether it is known, sticky error.
  bit m_exp = 1'b0;
  bit m_known = 1'b0;
  bit m_err = 1'b0;
  bit sb_err = 1'b0;
  bit sb_expq = 1'b0;

  function automatic bit jk_next(input bit q, input int c);
    case (c)
      1: return 1'b0;
      2: return 1'b1;
      3: return ~q;
      default: return q;
    endcase
  endfunction

  task automatic model_reset();
    sb_q.delete();
    m_exp = 1'b0; m_known = 1'b0; m_err = 1'b0;
    sb_err = 1'b0; sb_expq = 1'b0;
    force_en = 1'b0; force_val = 1'b0;
  endtask

  task automatic push_expected(input int cmd, input int cnt, input int acc,
                               input bit fen, input bit fval);
    item_t it;
    bit    qfb;
    it.cmd = cmd; it.cnt = cnt; it.acc = acc;
    it.err_before = m_err;
    for (int i = 0; i < cnt; i++) m_exp = jk_next(m_exp, cmd);
    if (cnt > 0 && (cmd == 1 || cmd == 2)) m_known = 1'b1;
    qfb = fen ? fval : m_exp;
    if (m_known && qfb != m_exp) m_err = 1'b1;
    it.exp_after = m_exp;
    it.err_after = m_err;
    sb_q.push_back(it);
  endtask

  // Called at posedge+1 or later; returns at posedge+1 of the cycle after accept.
  task automatic issue(input int cmd, input int cnt, input bit fen, input bit fval,
                       output int acc);
    bit got;
    got = 1'b0;
    acc = -1;
    CMD = 2'(cmd);
    CNT = CNT_W'(cnt);
    CMD_VALID = 1'b1;
    for (int w = 0; w < 50 && !got; w++) begin
      @(negedge CLK); #1;
      if (CMD_READY) begin
        got = 1'b1;
        acc = cyc;
        force_en = fen;
        force_val = fval;
        push_expected(cmd, cnt, acc, fen, fval);
      end
      @(posedge CLK); #1;
    end
    CMD_VALID = 1'b0;
    if (!got) chk("accept_timeout", 0, 1);
  endtask

  // Noise on the command inputs while busy; all of it must be ignored.
  task automatic busy_junk(input int n, input bit valid_hi);
    for (int i = 0; i < n; i++) begin
      CMD = 2'($urandom_range(0, 3));
      CNT = CNT_W'($urandom_range(0, 15));
      CMD_VALID = valid_hi ? 1'b1 : 1'($urandom_range(0, 1));
      @(posedge CLK); #1;
    end
    if (!valid_hi) CMD_VALID = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_j"}, J, 0);
    chk({tag, "_k"}, K, 0);
    chk({tag, "_ready"}, CMD_READY, 1);
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_done"}, DONE, 0);
    chk({tag, "_err"}, ERR, 0);
    chk({tag, "_expq"}, EXP_Q, 0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge CLK); #3;
    RST_N = 1'b0;
    CMD_VALID = 1'b0;
    model_reset();
    #1;
    reset_checks(tag);
    repeat (2) @(posedge CLK);
    #3;
    chk({tag, "_held_done"}, DONE, 0);
    RST_N = 1'b1;
  endtask

  // Monitor: every cycle, compare outputs against the in-flight scoreboard item.
  bit    mon_busy, mon_done, mon_drv;
  int    mon_jk;
  bit    mon_err;
  item_t mon_it;
  always @(negedge CLK) begin
    if (RST_N) begin
      mon_busy = 1'b0; mon_done = 1'b0; mon_drv = 1'b0;
      mon_jk = 0; mon_err = sb_err;
      if (sb_q.size() > 0) begin
        mon_it = sb_q[0];
        mon_drv  = (cyc > mon_it.acc) && (cyc <= mon_it.acc + mon_it.cnt);
        mon_busy = (cyc > mon_it.acc) && (cyc <= mon_it.acc + mon_it.cnt + 1);
        mon_done = (cyc == mon_it.acc + mon_it.cnt + 2);
        if (mon_drv) mon_jk = mon_it.cmd;
        mon_err = mon_done ? mon_it.err_after : mon_it.err_before;
      end
      chk("jk", {J, K}, mon_jk);
      chk("busy", BUSY, mon_busy);
      chk("ready", CMD_READY, !mon_busy);
      chk("done", DONE, mon_done);
      chk("err", ERR, mon_err);
      if (mon_done) begin
        chk("exp_q", EXP_Q, mon_it.exp_after);
        sb_err = mon_it.err_after;
        sb_expq = mon_it.exp_after;
        $display("txn acc=%0d cmd=%0d cnt=%0d exp_q=%0b err=%0b",
                 mon_it.acc, mon_it.cmd, mon_it.cnt, mon_it.exp_after, mon_it.err_after);
        void'(sb_q.pop_front());
      end else if (sb_q.size() == 0) begin
        chk("exp_q_idle", EXP_Q, sb_expq);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, cmd, cnt, gap;
    bit fen;

    #1 RST_N = 1'b0;
    model_reset();
    #1 reset_checks("por");
    repeat (2) @(posedge CLK);
    #3 RST_N = 1'b1;

    // TOGGLE while the flop state is unknown: a mismatching feedback is not an error.
    issue(3, 1, 1'b1, 1'b0, a1);
    busy_junk(2, 1'b0);
    chk("unknown_done", DONE, 1);
    chk("unknown_err", ERR, 0);

    // SET for one cycle.
    issue(2, 1, 1'b0, 1'b0, a1);
    busy_junk(2, 1'b0);
    chk("set_done", DONE, 1);
    chk("set_expq", EXP_Q, 1);
    chk("set_qfb", Q_FB, 1);
    chk("set_err", ERR, 0);

    // TOGGLE three times after SET.
    issue(3, 3, 1'b0, 1'b0, a1);
    busy_junk(4, 1'b0);
    chk("tog_done", DONE, 1);
    chk("tog_expq", EXP_Q, 0);
    chk("tog_err", ERR, 0);

    // HOLD with zero count, next command held valid into the DONE cycle.
    issue(0, 0, 1'b0, 1'b0, a1);
    busy_junk(1, 1'b1);
    chk("cnt0_done", DONE, 1);
    issue(2, 2, 1'b0, 1'b0, a2);
    chk("b2b_accept_cycle", a2, a1 + 2);
    busy_junk(3, 1'b0);

    // RESET with feedback stuck high flags an error that stays through HOLD.
    issue(1, 2, 1'b1, 1'b1, a1);
    busy_junk(3, 1'b0);
    chk("mis_err", ERR, 1);
    issue(0, 1, 1'b0, 1'b0, a1);
    busy_junk(2, 1'b0);
    chk("sticky_err", ERR, 1);

    // Long TOGGLE aborted by reset partway through DRIVE.
    issue(3, 15, 1'b0, 1'b0, a1);
    repeat (3) @(posedge CLK);
    #1 chk("long_drive_jk", {J, K}, 3);
    do_reset("abort");

    // Randomized traffic with occasional feedback corruption.
    for (int n = 0; n < 40; n++) begin
      cmd = $urandom_range(0, 3);
      cnt = ($urandom_range(0, 5) == 0) ? 15 : $urandom_range(0, 15);
      fen = ($urandom_range(0, 5) == 0);
      issue(cmd, cnt, fen, 1'($urandom_range(0, 1)), a1);
      busy_junk(cnt + 1, 1'b0);
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge CLK); #1;
      end
    end

    repeat (4) @(posedge CLK);
    #1 chk("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
